// File: rtl/cpu_memory_responder_pkg.sv
// Shared definitions for the stack CPU memory responder: loader state encoding
// and default memory geometry.
package cpu_memory_responder_pkg;
    localparam int DEF_WIDTH_DATA = 32;
    localparam int DEF_AWIDTH     = 5;
    localparam int DEF_DAWIDTH    = 10;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;
endpackage

// File: rtl/cpu_memory_responder_if.sv
// CPU fetch/data ports plus the program-load stream, bundled between the
// CPU/program source (master) and the memory responder (slave).
interface cpu_memory_responder_if #(
    parameter int WIDTH_DATA = 32,
    parameter int AWIDTH     = 5,
    parameter int DAWIDTH    = 10
);
    logic                  read_inst_enable;
    logic [AWIDTH-1:0]     address_memory_inst;
    logic [WIDTH_DATA-1:0] instruction;
    logic                  inst_valid;
    logic                  read_data_enable;
    logic                  write_data_enable;
    logic [DAWIDTH-1:0]    address_memory_data;
    logic [WIDTH_DATA-1:0] memory_data_out;
    logic [WIDTH_DATA-1:0] memory_data_in;
    logic                  data_valid;
    logic                  write_ack;
    logic                  load_start;
    logic                  load_valid;
    logic                  load_last;
    logic [WIDTH_DATA-1:0] load_word;
    logic                  load_ready;
    logic                  load_done;
    logic                  cpu_hold;

    modport master (
        output read_inst_enable, address_memory_inst, read_data_enable,
               write_data_enable, address_memory_data, memory_data_out,
               load_start, load_valid, load_last, load_word,
        input  instruction, inst_valid, memory_data_in, data_valid, write_ack,
               load_ready, load_done, cpu_hold
    );

    modport slave (
        input  read_inst_enable, address_memory_inst, read_data_enable,
               write_data_enable, address_memory_data, memory_data_out,
               load_start, load_valid, load_last, load_word,
        output instruction, inst_valid, memory_data_in, data_valid, write_ack,
               load_ready, load_done, cpu_hold
    );
endinterface

// File: rtl/cpu_memory_responder_sync_ram.sv
// Single-write-port RAM with a registered, read-before-write read port whose
// output holds until the next read and clears on reset.
module sync_ram #(
    parameter int WIDTH = 32,
    parameter int ABITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [ABITS-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [2**ABITS];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Sampling mem before the edge gives the pre-write word on a same-address collision.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    // Contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/cpu_memory_responder.sv
// Memory responder for the stack CPU: boot-loads instruction memory while the
// CPU is held in reset, then serves fetches and data reads/writes.
module cpu_memory_responder
    import cpu_memory_responder_pkg::*;
#(
    parameter int WIDTH_DATA = DEF_WIDTH_DATA,
    parameter int AWIDTH     = DEF_AWIDTH,
    parameter int DAWIDTH    = DEF_DAWIDTH
) (
    input logic                   clk,
    input logic                   reset,
    cpu_memory_responder_if.slave bus
);
    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   load_ptr_q, load_ptr_d;
    logic [AWIDTH-1:0]   load_idx;
    logic                imem_we;
    logic                run;
    logic                inst_valid_q, inst_valid_d;
    logic                data_valid_q, data_valid_d;
    logic                write_ack_q, write_ack_d;

    assign run = (state_q == ST_RUN);

    // A restart in the same cycle as a word places that word at address 0.
    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        load_idx   = load_ptr_q;
        imem_we    = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (bus.load_start) begin
                    state_d    = ST_LOAD;
                    load_ptr_d = '0;
                end
            end
            ST_LOAD: begin
                if (bus.load_start) begin
                    load_idx   = '0;
                    load_ptr_d = '0;
                end
                if (bus.load_valid) begin
                    imem_we    = 1'b1;
                    load_ptr_d = load_idx + 1'b1;
                    if (bus.load_last || (&load_idx)) state_d = ST_RUN;
                end
            end
            ST_RUN:  ;
            default: state_d = ST_HOLD;
        endcase
    end

    always_comb begin
        inst_valid_d = run && bus.read_inst_enable;
        data_valid_d = run && bus.read_data_enable;
        write_ack_d  = run && bus.write_data_enable;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            load_ptr_q   <= '0;
            inst_valid_q <= 1'b0;
            data_valid_q <= 1'b0;
            write_ack_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            inst_valid_q <= inst_valid_d;
            data_valid_q <= data_valid_d;
            write_ack_q  <= write_ack_d;
        end
    end

    sync_ram #(.WIDTH(WIDTH_DATA), .ABITS(AWIDTH)) u_imem (
        .clk   (clk),
        .reset (reset),
        .we    (imem_we),
        .waddr (load_idx),
        .wdata (bus.load_word),
        .re    (inst_valid_d),
        .raddr (bus.address_memory_inst),
        .rdata (bus.instruction)
    );

    sync_ram #(.WIDTH(WIDTH_DATA), .ABITS(DAWIDTH)) u_dmem (
        .clk   (clk),
        .reset (reset),
        .we    (write_ack_d),
        .waddr (bus.address_memory_data),
        .wdata (bus.memory_data_out),
        .re    (data_valid_d),
        .raddr (bus.address_memory_data),
        .rdata (bus.memory_data_in)
    );

    assign bus.inst_valid = inst_valid_q;
    assign bus.data_valid = data_valid_q;
    assign bus.write_ack  = write_ack_q;
    assign bus.load_ready = (state_q == ST_LOAD);
    assign bus.load_done  = run;
    assign bus.cpu_hold   = !run;
endmodule

// File: tb/tb_cpu_memory_responder.sv
// Scoreboard bench for cpu_memory_responder: expected read words are queued as
// requests are driven and checked when inst_valid/data_valid pulse.
module tb_cpu_memory_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int compared = 0;
    int mismatched = 0;

    logic [31:0] inst_q[$];
    logic [31:0] data_q[$];
    logic [31:0] imem_m[32];
    logic [31:0] dmem_m[1024];

    cpu_memory_responder_if #(.WIDTH_DATA(32), .AWIDTH(5), .DAWIDTH(10)) bus();

    cpu_memory_responder #(.WIDTH_DATA(32), .AWIDTH(5), .DAWIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: each valid pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (!reset) begin
            if (bus.inst_valid) begin
                compared++;
                if (inst_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL inst_unexpected: inst_valid with instruction=%h, no fetch outstanding", bus.instruction);
                end else begin
                    exp = inst_q.pop_front();
                    if (bus.instruction !== exp) begin
                        mismatched++;
                        $display("FAIL inst_data: got %h expected %h", bus.instruction, exp);
                    end
                end
            end
            if (bus.data_valid) begin
                compared++;
                if (data_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL data_unexpected: data_valid with memory_data_in=%h, no read outstanding", bus.memory_data_in);
                end else begin
                    exp = data_q.pop_front();
                    if (bus.memory_data_in !== exp) begin
                        mismatched++;
                        $display("FAIL data_read: got %h expected %h", bus.memory_data_in, exp);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.read_inst_enable    = 1'b0;
        bus.address_memory_inst = '0;
        bus.read_data_enable    = 1'b0;
        bus.write_data_enable   = 1'b0;
        bus.address_memory_data = '0;
        bus.memory_data_out     = '0;
        bus.load_start          = 1'b0;
        bus.load_valid          = 1'b0;
        bus.load_last           = 1'b0;
        bus.load_word           = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load_words(input logic [31:0] base, input int n, input bit last_on_final);
        bus.load_start = 1'b1;
        cyc();
        bus.load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1'b1;
            bus.load_word  = base + 32'(i);
            bus.load_last  = last_on_final && (i == n - 1);
            check_bit("load_ready_during_load", bus.load_ready, 1'b1);
            imem_m[i] = base + 32'(i);
            cyc();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        cyc();
        check_word("reset_instruction", bus.instruction, 32'h0);
        check_word("reset_memory_data_in", bus.memory_data_in, 32'h0);
        check_bit("reset_inst_valid", bus.inst_valid, 1'b0);
        check_bit("reset_data_valid", bus.data_valid, 1'b0);
        check_bit("reset_write_ack", bus.write_ack, 1'b0);
        check_bit("reset_load_ready", bus.load_ready, 1'b0);
        check_bit("reset_load_done", bus.load_done, 1'b0);
        check_bit("reset_cpu_hold", bus.cpu_hold, 1'b1);
        reset = 1'b0;
    endtask

    task automatic test_load3();
        logic [31:0] w[3];
        w[0] = 32'h0800_0005; w[1] = 32'h2000_0001; w[2] = 32'hA000_0000;
        bus.load_start = 1'b1;
        cyc();
        bus.load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_word  = w[i];
            bus.load_last  = (i == 2);
            check_bit("load3_ready", bus.load_ready, 1'b1);
            check_bit("load3_hold_while_loading", bus.cpu_hold, 1'b1);
            imem_m[i] = w[i];
            cyc();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check_bit("load3_cpu_hold_fell", bus.cpu_hold, 1'b0);
        check_bit("load3_load_done", bus.load_done, 1'b1);
        check_bit("load3_ready_dropped", bus.load_ready, 1'b0);
        bus.read_inst_enable    = 1'b1;
        bus.address_memory_inst = 5'd1;
        inst_q.push_back(imem_m[1]);
        cyc();
        bus.read_inst_enable = 1'b0;
        cyc();
        check_bit("fetch_valid_one_cycle", bus.inst_valid, 1'b0);
        check_word("fetch_instruction_held", bus.instruction, 32'h2000_0001);
        bus.read_inst_enable = 1'b1;
        for (int a = 0; a < 3; a++) begin
            bus.address_memory_inst = 5'(a);
            inst_q.push_back(imem_m[a]);
            cyc();
        end
        bus.read_inst_enable = 1'b0;
        cyc();
    endtask

    task automatic test_write_read_top();
        bus.write_data_enable   = 1'b1;
        bus.address_memory_data = 10'd1023;
        bus.memory_data_out     = 32'hDEAD_BEEF;
        dmem_m[1023] = 32'hDEAD_BEEF;
        cyc();
        bus.write_data_enable = 1'b0;
        check_bit("write_ack_pulse", bus.write_ack, 1'b1);
        bus.read_data_enable = 1'b1;
        data_q.push_back(dmem_m[1023]);
        cyc();
        check_bit("write_ack_one_cycle", bus.write_ack, 1'b0);
        bus.read_data_enable = 1'b0;
        cyc();
        check_bit("data_valid_dropped", bus.data_valid, 1'b0);
        check_word("read_data_held", bus.memory_data_in, 32'hDEAD_BEEF);
    endtask

    task automatic test_read_before_write();
        bus.write_data_enable   = 1'b1;
        bus.address_memory_data = 10'd7;
        bus.memory_data_out     = 32'h11;
        dmem_m[7] = 32'h11;
        cyc();
        bus.read_data_enable = 1'b1;
        bus.memory_data_out  = 32'h22;
        data_q.push_back(dmem_m[7]);
        dmem_m[7] = 32'h22;
        cyc();
        bus.write_data_enable = 1'b0;
        data_q.push_back(dmem_m[7]);
        cyc();
        bus.read_data_enable = 1'b0;
        cyc();
    endtask

    task automatic test_requests_during_load();
        do_reset();
        bus.load_start = 1'b1;
        cyc();
        bus.load_start          = 1'b0;
        bus.read_inst_enable    = 1'b1;
        bus.read_data_enable    = 1'b1;
        bus.write_data_enable   = 1'b1;
        bus.address_memory_data = 10'd7;
        bus.memory_data_out     = 32'h99;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_bit("load_drop_write_ack", bus.write_ack, 1'b0);
            check_bit("load_drop_inst_valid", bus.inst_valid, 1'b0);
        end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            bus.load_valid = 1'b1;
            bus.load_word  = 32'h5000_0000 + 32'(i);
            bus.load_last  = (i == 1);
            imem_m[i] = 32'h5000_0000 + 32'(i);
            cyc();
        end
        idle_inputs();
        check_bit("load2_done", bus.load_done, 1'b1);
        bus.read_data_enable    = 1'b1;
        bus.address_memory_data = 10'd7;
        data_q.push_back(dmem_m[7]);
        bus.read_inst_enable    = 1'b1;
        bus.address_memory_inst = 5'd2;
        inst_q.push_back(imem_m[2]);
        cyc();
        idle_inputs();
        cyc();
    endtask

    task automatic test_reset_midload();
        do_reset();
        load_words(32'hAAAA_0000, 2, 1'b0);
        check_bit("midload_still_loading", bus.load_ready, 1'b1);
        reset = 1'b1;
        cyc();
        check_bit("midload_reset_cpu_hold", bus.cpu_hold, 1'b1);
        check_bit("midload_reset_load_ready", bus.load_ready, 1'b0);
        check_bit("midload_reset_load_done", bus.load_done, 1'b0);
        check_word("midload_reset_memory_data_in", bus.memory_data_in, 32'h0);
        check_word("midload_reset_instruction", bus.instruction, 32'h0);
        reset = 1'b0;
        load_words(32'hBBBB_0000, 2, 1'b1);
        check_bit("reload_done", bus.load_done, 1'b1);
        bus.read_inst_enable = 1'b1;
        for (int a = 0; a < 3; a++) begin
            bus.address_memory_inst = 5'(a);
            inst_q.push_back(imem_m[a]);
            cyc();
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_full32();
        do_reset();
        load_words(32'hC000_0100, 32, 1'b0);
        check_bit("full32_run", bus.load_done, 1'b1);
        check_bit("full32_cpu_hold", bus.cpu_hold, 1'b0);
        bus.load_valid = 1'b1;
        bus.load_start = 1'b1;
        bus.load_last  = 1'b1;
        bus.load_word  = 32'hFFFF_FFFF;
        cyc();
        idle_inputs();
        check_bit("word33_ignored_done", bus.load_done, 1'b1);
        check_bit("word33_ignored_ready", bus.load_ready, 1'b0);
        bus.read_inst_enable = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bus.address_memory_inst = 5'(a);
            inst_q.push_back(imem_m[a]);
            cyc();
        end
        idle_inputs();
        cyc();
        cyc();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load3();
        test_write_read_top();
        test_read_before_write();
        test_requests_during_load();
        test_reset_midload();
        test_full32();
        cyc();
        compared++;
        if (inst_q.size() != 0 || data_q.size() != 0) begin
            mismatched++;
            $display("FAIL outstanding_reads: %0d fetches and %0d data reads never returned, required 0",
                     inst_q.size(), data_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
